// File: rtl/z80_intc_pkg.sv
// Shared constants for the Z80 mode-2 interrupt controller: register offsets
// relative to BASE_PORT and the opcode bytes that make up RETI.
package z80_intc_pkg;

    localparam logic [7:0] OFS_MASK  = 8'd0;
    localparam logic [7:0] OFS_PEND  = 8'd1;
    localparam logic [7:0] OFS_INSVC = 8'd2;

    localparam logic [7:0] OP_ED    = 8'hED;
    localparam logic [7:0] OP_RETI2 = 8'h4D;

endpackage

// File: rtl/z80_intc_if.sv
// Z80 CPU-side bus seen by the interrupt controller: address/data, control
// strobes, vector/register read-back and the nINT request.
interface z80_intc_if;
    logic [7:0] A;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;
    logic       nM1;
    logic       nMREQ;
    logic       nIORQ;
    logic       nRD;
    logic       nWR;
    logic       nINT;

    modport master (
        output A, D_in, nM1, nMREQ, nIORQ, nRD, nWR,
        input  D_out, D_oe, nINT
    );

    modport slave (
        input  A, D_in, nM1, nMREQ, nIORQ, nRD, nWR,
        output D_out, D_oe, nINT
    );
endinterface

// File: rtl/z80_intc_prio.sv
// Find-first-set over WIDTH bits; bit 0 wins. Index is always 3 bits wide so
// callers see one type regardless of source count.
module intc_prio #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] bits,
    output logic             valid,
    output logic [2:0]       index
);

    always_comb begin
        valid = 1'b0;
        index = 3'd0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (bits[i]) begin
                valid = 1'b1;
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/z80_intc.sv
// Vectored, prioritised IM 2 interrupt controller: edge-captures requests, drives
// nINT, supplies the vector on acknowledge and retires levels by snooping RETI.
module z80_intc
    import z80_intc_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 8,
    parameter logic [7:0]  VEC_BASE  = 8'hE0,
    parameter logic [7:0]  BASE_PORT = 8'h40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    z80_intc_if.slave          bus
);

    localparam logic [7:0] SRC_MASK = 8'((16'd1 << NUM_SRC) - 16'd1);

    logic [7:0] irq8, irq_prev_q, edges;
    logic [7:0] pending_q, pending_d, mask_q, mask_d, insvc_q, insvc_d;
    logic [7:0] masked, ack_set, w1c, reti_clr, ofs, op_q;
    logic [2:0] ack_idx_q, ack_idx_cur, cand_idx, isv_idx;
    logic       cand_valid, isv_valid, int_req;
    logic       ack_cond, ack_prev_q, ack_start;
    logic       wr_start, wr_prev_q, rd_sel;
    logic       fetch, fetch_prev_q, commit, reti;
    logic       prefix_q, prefix_d, nint_q;

    assign irq8   = 8'(irq_src);
    assign masked = pending_q & mask_q;
    assign ofs    = bus.A - BASE_PORT;

    intc_prio #(.WIDTH(NUM_SRC)) u_cand (
        .bits  (masked[NUM_SRC-1:0]),
        .valid (cand_valid),
        .index (cand_idx)
    );

    intc_prio #(.WIDTH(NUM_SRC)) u_insvc (
        .bits  (insvc_q[NUM_SRC-1:0]),
        .valid (isv_valid),
        .index (isv_idx)
    );

    assign ack_cond  = !bus.nM1 && !bus.nIORQ;
    assign ack_start = ack_cond && !ack_prev_q;
    assign wr_start  = !bus.nIORQ && !bus.nWR && !wr_prev_q;
    assign rd_sel    = !bus.nIORQ && !bus.nRD && bus.nM1 && (ofs <= OFS_INSVC);
    assign fetch     = !bus.nM1 && !bus.nMREQ && !bus.nRD;
    assign commit    = fetch_prev_q && !fetch;
    assign reti      = commit && prefix_q && (op_q == OP_RETI2);
    assign int_req   = cand_valid && (!isv_valid || cand_idx < isv_idx);

    // Bypass so the vector is correct in the very cycle the ack appears.
    assign ack_idx_cur = ack_start ? (cand_valid ? cand_idx : 3'd0) : ack_idx_q;

    always_comb begin
        edges    = irq8 & ~irq_prev_q & SRC_MASK;
        ack_set  = (ack_start && cand_valid) ? (8'd1 << cand_idx) : 8'd0;
        w1c      = (wr_start && ofs == OFS_PEND) ? bus.D_in : 8'd0;
        reti_clr = (reti && isv_valid) ? (8'd1 << isv_idx) : 8'd0;
        mask_d   = (wr_start && ofs == OFS_MASK) ? (bus.D_in & SRC_MASK) : mask_q;
        // New edges win over clears; RETI uses the pre-ack in-service state.
        pending_d = ((pending_q & ~w1c & ~ack_set) | edges) & SRC_MASK;
        insvc_d   = ((insvc_q & ~reti_clr) | ack_set) & SRC_MASK;
        prefix_d  = prefix_q;
        if (commit) prefix_d = (op_q == OP_ED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q   <= 8'd0;
            pending_q    <= 8'd0;
            mask_q       <= 8'd0;
            insvc_q      <= 8'd0;
            op_q         <= 8'd0;
            ack_idx_q    <= 3'd0;
            ack_prev_q   <= 1'b0;
            wr_prev_q    <= 1'b0;
            fetch_prev_q <= 1'b0;
            prefix_q     <= 1'b0;
            nint_q       <= 1'b1;
        end else begin
            irq_prev_q   <= irq8;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            insvc_q      <= insvc_d;
            ack_idx_q    <= ack_idx_cur;
            ack_prev_q   <= ack_cond;
            wr_prev_q    <= !bus.nIORQ && !bus.nWR;
            fetch_prev_q <= fetch;
            prefix_q     <= prefix_d;
            nint_q       <= !int_req;
            if (fetch) op_q <= bus.D_in;
        end
    end

    always_comb begin
        bus.D_oe  = 1'b0;
        bus.D_out = 8'd0;
        if (!reset) begin
            if (ack_cond) begin
                bus.D_oe  = 1'b1;
                bus.D_out = VEC_BASE | {4'd0, ack_idx_cur, 1'b0};
            end else if (rd_sel) begin
                bus.D_oe = 1'b1;
                case (ofs)
                    OFS_MASK: bus.D_out = mask_q;
                    OFS_PEND: bus.D_out = pending_q;
                    default:  bus.D_out = insvc_q;
                endcase
            end
        end
    end

    assign bus.nINT = nint_q;

endmodule

// File: tb/tb_z80_intc.sv
// Randomised scoreboard bench for z80_intc: a transaction-level model predicts
// vectors, register reads and nINT; a monitor checks every driven bus byte.
module tb_z80_intc;
    localparam logic [7:0] BASE = 8'h40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq_src = 8'd0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m_mask, m_pend, m_isv;
    logic       m_prefix;

    z80_intc_if bus ();

    z80_intc #(.NUM_SRC(8), .VEC_BASE(8'hE0), .BASE_PORT(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: each new bus drive is matched against the oldest expectation.
    logic oe_seen = 1'b0;
    always @(negedge clk) begin
        if (bus.D_oe && !oe_seen) begin
            if (sb.size() == 0) begin
                check("unexpected_drive", bus.D_out, 8'hxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, bus.D_out, e.val);
            end
        end
        oe_seen = bus.D_oe;
    end

    function automatic int m_cand();
        for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    function automatic int m_low_isv();
        for (int i = 0; i < 8; i++) if (m_isv[i]) return i;
        return 8;
    endfunction

    function automatic logic m_nint();
        int c;
        c = m_cand();
        return !(c >= 0 && c < m_low_isv());
    endfunction

    task automatic model_reset();
        m_mask = 0; m_pend = 0; m_isv = 0; m_prefix = 0;
    endtask

    task automatic bus_idle();
        bus.nM1 = 1; bus.nMREQ = 1; bus.nIORQ = 1; bus.nRD = 1; bus.nWR = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus_idle();
        end
    endtask

    task automatic io_write(input logic [7:0] ofs, input logic [7:0] d);
        @(posedge clk); #1;
        bus.A = BASE + ofs; bus.D_in = d; bus.nIORQ = 0; bus.nWR = 0;
        @(posedge clk);
        idle(2);
        if (ofs == 0) m_mask = d;
        else if (ofs == 1) m_pend &= ~d;
    endtask

    task automatic io_read(input logic [7:0] ofs, input string name);
        logic [7:0] v;
        v = (ofs == 0) ? m_mask : (ofs == 1) ? m_pend : m_isv;
        sb.push_back('{name, v});
        @(posedge clk); #1;
        bus.A = BASE + ofs; bus.nIORQ = 0; bus.nRD = 0;
        @(posedge clk);
        idle(2);
    endtask

    task automatic ack(input string name);
        int c;
        c = m_cand();
        sb.push_back('{name, (c >= 0) ? (8'hE0 | 8'(c << 1)) : 8'hE0});
        if (c >= 0) begin
            m_pend[c] = 1'b0;
            m_isv[c]  = 1'b1;
        end
        @(posedge clk); #1;
        bus.nM1 = 0; bus.nIORQ = 0;
        @(posedge clk);
        idle(2);
    endtask

    task automatic fetch(input logic [7:0] op);
        @(posedge clk); #1;
        bus.D_in = op; bus.nM1 = 0; bus.nMREQ = 0; bus.nRD = 0;
        @(posedge clk);
        idle(2);
        if (op == 8'hED) m_prefix = 1;
        else begin
            if (op == 8'h4D && m_prefix && m_low_isv() < 8) m_isv[m_low_isv()] = 1'b0;
            m_prefix = 0;
        end
    endtask

    task automatic pulse(input int src);
        @(posedge clk); #1;
        irq_src[src] = 1'b1;
        @(posedge clk); #1;
        irq_src[src] = 1'b0;
        m_pend[src] = 1'b1;
    endtask

    task automatic chk_nint(input string name);
        idle(2);
        @(negedge clk);
        check(name, {7'd0, bus.nINT}, {7'd0, m_nint()});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus_idle();
        bus.A = 0; bus.D_in = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_nint", {7'd0, bus.nINT}, 8'd1);
        check("reset_oe", {7'd0, bus.D_oe}, 8'd0);
        io_read(0, "reset_mask");
        io_read(1, "reset_pend");
        io_read(2, "reset_insvc");

        // Basic flow with cycle-exact edge -> pending -> nINT timing.
        io_write(0, 8'h0F);
        @(posedge clk); #1 irq_src[2] = 1'b1;
        @(posedge clk); #1 irq_src[2] = 1'b0;
        m_pend[2] = 1'b1;
        @(negedge clk);
        check("nint_after_1", {7'd0, bus.nINT}, 8'd1);
        @(negedge clk);
        check("nint_after_2", {7'd0, bus.nINT}, 8'd0);
        io_read(1, "pend_04");
        ack("vec_e4");
        io_read(2, "insvc_04");
        io_read(1, "pend_00");
        chk_nint("nint_high_after_ack");

        // Nesting and RETI handling.
        pulse(0);
        chk_nint("nint_nest_low");
        ack("vec_e0");
        io_read(2, "insvc_05");
        pulse(3);
        chk_nint("nint_src3_blocked");
        fetch(8'hED); fetch(8'h4D);
        io_read(2, "insvc_reti1");
        fetch(8'hED); fetch(8'h4D);
        io_read(2, "insvc_reti2");
        ack("vec_e6");
        fetch(8'hED); fetch(8'h00); fetch(8'h4D);
        io_read(2, "insvc_no_reti");
        fetch(8'hED); fetch(8'hED); fetch(8'h4D);
        io_read(2, "insvc_ed_ed_4d");

        // W1C of bit 2 in the same cycle as a new edge on source 2.
        @(posedge clk); #1;
        bus.A = BASE + 8'd1; bus.D_in = 8'h04; bus.nIORQ = 0; bus.nWR = 0;
        irq_src[2] = 1'b1;
        @(posedge clk); #1 irq_src[2] = 1'b0;
        idle(2);
        m_pend[2] = 1'b1;
        io_read(1, "pend_w1c_vs_edge");

        io_write(0, 8'h00);
        chk_nint("nint_masked");
        ack("vec_spurious");
        io_read(2, "insvc_spurious");

        // Randomised traffic.
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 6))
                0: pulse($urandom_range(0, 7));
                1: io_write(0, 8'($urandom));
                2: io_write(1, 8'($urandom));
                3: ack("rnd_vec");
                4: begin
                    logic [7:0] op;
                    case ($urandom_range(0, 3))
                        0: op = 8'hED;
                        1: op = 8'h4D;
                        2: op = 8'h00;
                        default: op = 8'($urandom);
                    endcase
                    fetch(op);
                end
                5: io_read(8'($urandom_range(0, 2)), "rnd_read");
                default: chk_nint("rnd_nint");
            endcase
        end

        // Reset asserted in the middle of an acknowledge.
        io_write(0, 8'hFF);
        pulse(5);
        idle(2);
        sb.push_back('{"vec_before_reset", 8'hE0 | 8'(m_cand() << 1)});
        @(posedge clk); #1;
        bus.nM1 = 0; bus.nIORQ = 0;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("reset_mid_ack_oe", {7'd0, bus.D_oe}, 8'd0);
        check("reset_mid_ack_nint", {7'd0, bus.nINT}, 8'd1);
        model_reset();
        @(posedge clk); #1 bus_idle();
        @(posedge clk); #1 reset = 1'b0;
        idle(1);
        io_read(0, "post_reset_mask");
        io_read(1, "post_reset_pend");
        io_read(2, "post_reset_insvc");
        idle(2);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
